// File: rtl/lsu_axi_master.sv
// Single-outstanding load/store unit bridge onto an AXI master port.
// Each core request becomes one AR/R or AW/W/B exchange, then a one-cycle completion pulse.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [2:0]          dbg_state
);

    // All channels use plain AXI valid/ready: a transfer happens on a posedge where both are high;
    // once a valid is raised, it and its payload stay put until that transfer.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done, w_done;
    logic                aw_hs, w_hs, aw_ok, w_ok, b_hs, r_hs;
    logic                unused_resp_bits;

    assign unused_resp_bits = ^{rresp[0], bresp[0]};

    // A write response only counts once both address and data are (or are becoming) complete.
    assign aw_hs = (state == S_WR) && !aw_done && awready;
    assign w_hs  = (state == S_WR) && !w_done && wready;
    assign aw_ok = aw_done || aw_hs;
    assign w_ok  = w_done || w_hs;
    assign b_hs  = bvalid && ((state == S_B) || ((state == S_WR) && aw_ok && w_ok));
    assign r_hs  = rvalid && (((state == S_AR) && arready) || (state == S_R));

    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_we ? S_WR : S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                rready  = 1'b1;
                if (arready) state_next = rvalid ? S_RESP : S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) state_next = S_RESP;
            end
            S_WR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                bready  = 1'b1;
                if (b_hs) state_next = S_RESP;
                else if (aw_ok && w_ok) state_next = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            // resp_rdata is only ever touched by a read, so it survives intervening writes.
            if (r_hs) begin
                resp_rdata <= rdata;
                resp_err   <= rresp[1];
            end
            if (b_hs) resp_err <= bresp[1];
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: scripted slave, transaction-level model checked every cycle,
// and literal expectations at the key cycles of each scenario.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [2:0]  dbg_state;
  logic        rvalid_follow, rvalid_drv;

  always #5 clk = ~clk;

  assign rvalid = rvalid_follow ? arvalid : rvalid_drv;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    step();
    req_valid = 1'b0;
  endtask

  // expected completions: {resp_err, read data (ignored for writes)}
  logic [32:0] exp_q[$];

  // Transaction-level model: one request in flight, rules checked on every negedge.
  logic        m_busy, m_we, m_first, m_ar_seen, m_aw_seen, m_w_seen, acc;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [32:0] e;

  initial begin
    m_busy = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0; m_first = 1'b0; m_rdata = '0;
        m_ar_seen = 1'b0; m_aw_seen = 1'b0; m_w_seen = 1'b0;
        exp_q.delete();
      end else begin
        chk("m_req_ready", req_ready, !m_busy);
        if (!m_busy) begin
          chk("m_idle_quiet", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
        end else if (!m_we) begin
          chk("m_rd_no_wr_ch", {awvalid, wvalid, bready}, 0);
          chk("m_rd_rready", rready, !resp_valid);
          if (m_first) chk("m_rd_arvalid_entry", arvalid, 1);
          if (m_ar_seen) chk("m_rd_arvalid_drop", arvalid, 0);
          if (arvalid) chk("m_araddr", araddr, m_addr);
          if (arvalid && arready) m_ar_seen = 1'b1;
        end else begin
          chk("m_wr_no_rd_ch", {arvalid, rready}, 0);
          chk("m_wr_bready", bready, !resp_valid);
          if (m_first) chk("m_wr_valids_entry", {awvalid, wvalid}, 2'b11);
          if (m_aw_seen) chk("m_awvalid_drop", awvalid, 0);
          if (m_w_seen) chk("m_wvalid_drop", wvalid, 0);
          if (awvalid) chk("m_awaddr", awaddr, m_addr);
          if (wvalid) begin
            chk("m_wdata", wdata, m_wdata);
            chk("m_wstrb", wstrb, m_wstrb);
          end
          if (awvalid && awready) m_aw_seen = 1'b1;
          if (wvalid && wready) m_w_seen = 1'b1;
        end
        m_first = 1'b0;
        acc = !m_busy && req_valid;
        if (resp_valid) begin
          chk("m_resp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("m_resp_err", resp_err, e[32]);
            if (!m_we) m_rdata = e[31:0];
          end
          m_busy = 1'b0;
        end
        chk("m_resp_rdata", resp_rdata, m_rdata);
        if (acc) begin
          m_busy = 1'b1; m_we = req_we; m_addr = req_addr;
          m_wdata = req_wdata; m_wstrb = req_wstrb; m_first = 1'b1;
          m_ar_seen = 1'b0; m_aw_seen = 1'b0; m_w_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid_follow = 1'b0; rvalid_drv = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    step();

    // zero-wait read
    rvalid_follow = 1'b1; arready = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h8000_0000);
    step();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_rdata", resp_rdata, 32'hDEADBEEF);
    chk("t1_err", resp_err, 0);
    chk("t1_arvalid_off", arvalid, 0);
    step();
    chk("t1_resp_pulse", resp_valid, 0);
    chk("t1_idle_ready", req_ready, 1);
    rvalid_follow = 1'b0; arready = 1'b0;
    step();

    // stalled read with a stray rvalid before the AR handshake
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    issue(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    chk("t2_arvalid_c1", arvalid, 1);
    step();
    rvalid_drv = 1'b1; rdata = 32'hBAD0BAD0; rresp = 2'b00;
    chk("t2_arvalid_c2", arvalid, 1);
    step();
    rvalid_drv = 1'b0; arready = 1'b1;
    chk("t2_araddr_c3", araddr, 32'h8000_0008);
    step();
    arready = 1'b0;
    chk("t2_arvalid_r", arvalid, 0);
    chk("t2_rready_r", rready, 1);
    step();
    rvalid_drv = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b10;
    chk("t2_no_resp_yet", resp_valid, 0);
    step();
    rvalid_drv = 1'b0;
    chk("t2_resp_valid", resp_valid, 1);
    chk("t2_rdata", resp_rdata, 32'hCAFEF00D);
    chk("t2_err", resp_err, 1);
    step();
    chk("t2_resp_pulse", resp_valid, 0);

    // split write: W first, AW two cycles later, then B
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
    wready = 1'b1;
    chk("t3_wvalid_c1", wvalid, 1);
    chk("t3_awvalid_c1", awvalid, 1);
    step();
    wready = 1'b0;
    chk("t3_wvalid_c2", wvalid, 0);
    chk("t3_awvalid_c2", awvalid, 1);
    step();
    awready = 1'b1;
    chk("t3_awvalid_c3", awvalid, 1);
    step();
    awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    chk("t3_awvalid_c4", awvalid, 0);
    chk("t3_bready_c4", bready, 1);
    step();
    bvalid = 1'b0;
    chk("t3_resp_valid", resp_valid, 1);
    chk("t3_err", resp_err, 0);
    chk("t3_rdata_kept", resp_rdata, 32'hCAFEF00D);
    step();

    // early bvalid must be ignored until AW and W are both done
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 4'b1111);
    awready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    step();
    awready = 1'b0;
    chk("t4_resp_c2", resp_valid, 0);
    chk("t4_wvalid_c2", wvalid, 1);
    step();
    wready = 1'b1; bvalid = 1'b0;
    chk("t4_resp_c3", resp_valid, 0);
    step();
    wready = 1'b0; bvalid = 1'b1; bresp = 2'b01;
    chk("t4_resp_c4", resp_valid, 0);
    chk("t4_bready_c4", bready, 1);
    step();
    bvalid = 1'b0;
    chk("t4_resp_valid", resp_valid, 1);
    chk("t4_err", resp_err, 0);
    step();

    // AW, W and B all in the first cycle: minimum-latency write with error
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b1, 32'h8000_0030, 32'h0F0F_0F0F, 4'b1100);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b11;
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    chk("t5_resp_valid", resp_valid, 1);
    chk("t5_err", resp_err, 1);
    step();
    chk("t5_resp_pulse", resp_valid, 0);
    chk("t5_idle_ready", req_ready, 1);
    step();

    // back-to-back: req_valid held through a read, write accepted right after
    rvalid_follow = 1'b1; arready = 1'b1; rdata = 32'h0BAD_CAFE; rresp = 2'b00;
    exp_q.push_back({1'b0, 32'h0BAD_CAFE});
    exp_q.push_back({1'b0, 32'h0});
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0040;
    step();
    chk("t6_busy_ready", req_ready, 0);
    req_we = 1'b1; req_addr = 32'h8000_0044; req_wdata = 32'h1122_3344; req_wstrb = 4'b1111;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    step();
    chk("t6_resp1", resp_valid, 1);
    chk("t6_resp1_ready", req_ready, 0);
    chk("t6_rdata", resp_rdata, 32'h0BAD_CAFE);
    step();
    chk("t6_idle_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("t6_awvalid", awvalid, 1);
    chk("t6_awaddr", awaddr, 32'h8000_0044);
    step();
    chk("t6_resp2", resp_valid, 1);
    chk("t6_rdata_kept", resp_rdata, 32'h0BAD_CAFE);
    rvalid_follow = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    step();

    // reset while waiting in R; the late rvalid must be ignored
    issue(1'b0, 32'h8000_0050, 32'h0, 4'h0);
    arready = 1'b1;
    chk("t7_arvalid", arvalid, 1);
    step();
    arready = 1'b0;
    chk("t7_rready_r", rready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rvalid_drv = 1'b1; rdata = 32'h5555_5555; rresp = 2'b10;
    chk("t7_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    chk("t7_req_ready", req_ready, 1);
    chk("t7_rdata_clr", resp_rdata, 0);
    chk("t7_err_clr", resp_err, 0);
    step();
    chk("t7_no_resp1", resp_valid, 0);
    step();
    chk("t7_no_resp2", resp_valid, 0);
    chk("t7_rdata_still", resp_rdata, 0);
    rvalid_drv = 1'b0;
    repeat (2) step();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
